numerador_escalonado_seq: RTL

- Sequential, parametrised successor to the fixed x100 numerator scaler in the fuzzy processor (_Proc_fuzzy).
- Accepts a vector of N_CH numerators from the membership (triangle/trapezoid) stages.
- Multiplies each numerator by K using one shared multiplier, one channel per cycle, with optional saturation. K=100 expresses degrees on a 0-100 scale instead of 0-1.
- Presents all results together to the defuzzification stage through a valid/ready handshake.

---
 rtl/numerador_escalonado_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/numerador_escalonado_seq.sv
// Sequential numerator scaler: multiplies N_CH captured numerators by K through one
// shared multiplier, one channel per cycle, and hands the full vector downstream.
module numerador_escalonado_seq #(
    parameter int N_CH = 2,
    parameter int W    = 32,
    parameter int KW   = 8,
    parameter int K    = 100,
    parameter int SAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] num_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*W-1:0] num_out,
    output logic [N_CH-1:0]   sat_flag
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [W+KW-1:0]  K_EXT    = (W+KW)'(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [IDX_W-1:0]    idx_r;
    logic [N_CH*W-1:0]   cap_r;
    logic [N_CH*W-1:0]   num_out_r;
    logic [N_CH-1:0]     sat_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [W-1:0]        cap_ch_s;
    logic [W+KW-1:0]     prod_s;
    logic [W:0]          res_s;

    // Overflow flag in the top bit; the wrapped value is kept when saturation is off.
    function automatic logic [W:0] scale_ch(input logic [W+KW-1:0] prod);
        logic ovf;
        ovf = |prod[W+KW-1:W];
        if (!ovf) begin
            scale_ch = {1'b0, prod[W-1:0]};
        end else if (SAT == 1) begin
            scale_ch = {1'b1, {W{1'b1}}};
        end else begin
            scale_ch = {1'b1, prod[W-1:0]};
        end
    endfunction

    // Shared multiplier datapath for the channel currently selected by idx.
    always_comb begin
        cap_ch_s = cap_r[idx_r*W +: W];
        prod_s   = {{KW{1'b0}}, cap_ch_s} * K_EXT;
        res_s    = scale_ch(prod_s);
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nx_s = BUSY;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            BUSY: begin
                if (idx_r == LAST_IDX) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and handshake outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    // Capture, channel index and result vector updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r     <= '0;
            cap_r     <= '0;
            num_out_r <= '0;
            sat_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        cap_r <= num_in;
                        sat_r <= '0;
                        idx_r <= '0;
                    end
                end
                BUSY: begin
                    num_out_r[idx_r*W +: W] <= res_s[W-1:0];
                    sat_r[idx_r]            <= res_s[W];
                    if (idx_r != LAST_IDX) begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    idx_r <= '0;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign num_out   = num_out_r;
    assign sat_flag  = sat_r;

endmodule
